branch_cmp_bht: RTL and testbench

Parametrised branch compare and prediction unit for the MIPS pipeline. It resolves conditional branches in decode (BEQ, BNE, BGTZ, BLEZ and the REGIMM BGEZ/BLTZ/BGEZAL/BLTZAL group) at a configurable data width. It also keeps a table of 2-bit saturating counters indexed by PC, which gives a taken prediction at fetch. A one-cycle registered resolve stage flags mispredictions, trains the table, and counts branches and mispredictions for performance monitoring.

---
 rtl/branch_cmp_bht.sv | 167 ++++++++++++++++
 tb/tb_branch_cmp_bht.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cmp_bht.sv
// Decode-stage branch condition unit with a PC-indexed table of 2-bit saturating
// counters, a one-cycle resolve register and saturating branch/mispredict counters.
module branch_cmp_bht #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              d_valid,
  input  logic              d_stall,
  input  logic              d_flush,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [5:0]        opD,
  input  logic [4:0]        rtD,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              d_pred_taken,
  output logic              d_is_branch,
  output logic              d_taken,
  output logic              r_valid,
  output logic              r_taken,
  output logic              r_mispredict,
  output logic [PC_W-1:0]   r_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  logic a_neg;
  logic a_zero;
  logic d_fire;

  assign a_neg  = a[DATA_W-1];
  assign a_zero = (a == '0);

  always_comb begin
    d_is_branch = 1'b0;
    d_taken     = 1'b0;
    case (opD)
      OP_BEQ:  begin d_is_branch = 1'b1; d_taken = (a == b);          end
      OP_BNE:  begin d_is_branch = 1'b1; d_taken = (a != b);          end
      OP_BGTZ: begin d_is_branch = 1'b1; d_taken = !a_neg && !a_zero; end
      OP_BLEZ: begin d_is_branch = 1'b1; d_taken = a_neg || a_zero;   end
      OP_REGIMM: begin
        case (rtD)
          RT_BGEZ, RT_BGEZAL: begin d_is_branch = 1'b1; d_taken = !a_neg; end
          RT_BLTZ, RT_BLTZAL: begin d_is_branch = 1'b1; d_taken = a_neg;  end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Flush dominates stall: either one blocks capture.
  assign d_fire = d_valid && d_is_branch && !d_stall && !d_flush;

  logic            r_valid_q, r_valid_d;
  logic            r_taken_q, r_taken_d;
  logic            r_mispredict_q, r_mispredict_d;
  logic [PC_W-1:0] r_pc_q, r_pc_d;

  always_comb begin
    r_valid_d      = d_fire;
    r_taken_d      = r_taken_q;
    r_mispredict_d = r_mispredict_q;
    r_pc_d         = r_pc_q;
    if (d_fire) begin
      r_taken_d      = d_taken;
      r_mispredict_d = d_taken ^ d_pred_taken;
      r_pc_d         = d_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_q      <= 1'b0;
      r_taken_q      <= 1'b0;
      r_mispredict_q <= 1'b0;
      r_pc_q         <= '0;
    end else begin
      r_valid_q      <= r_valid_d;
      r_taken_q      <= r_taken_d;
      r_mispredict_q <= r_mispredict_d;
      r_pc_q         <= r_pc_d;
    end
  end

  assign r_valid      = r_valid_q;
  assign r_taken      = r_taken_q;
  assign r_mispredict = r_mispredict_q;
  assign r_pc         = r_pc_q;

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       bht_rd [BHT_DEPTH];

  assign f_idx = f_pc[IDX_W+1:2];
  assign r_idx = r_pc_q[IDX_W+1:2];

  // Each entry trains only from the resolve register, so fetch sees the old value.
  for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
    logic [1:0] ent_q, ent_d;
    logic       hit;

    assign hit = r_valid_q && (r_idx == IDX_W'(gi));

    always_comb begin
      ent_d = ent_q;
      if (hit) begin
        if (r_taken_q && ent_q != 2'b11)       ent_d = ent_q + 2'd1;
        else if (!r_taken_q && ent_q != 2'b00) ent_d = ent_q - 2'd1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) ent_q <= 2'b01;
      else     ent_q <= ent_d;
    end

    assign bht_rd[gi] = ent_q;
  end

  assign f_pred_taken = bht_rd[f_idx][1];

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (r_valid_q && branch_cnt_q != '1)
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (r_valid_q && r_mispredict_q && mispredict_cnt_q != '1)
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0]};
endmodule

// File: tb/tb_branch_cmp_bht.sv
// Scoreboard bench for branch_cmp_bht: a 32-bit default instance plus a narrow
// 16-bit instance with 4-bit counters for sign-bit and saturation corners.
module tb_branch_cmp_bht;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic [31:0] f_pc = '0, d_pc = '0, a = '0, b = '0, r_pc;
  logic        f_pred_taken, d_is_branch, d_taken, r_valid, r_taken, r_mispredict;
  logic        d_valid = 1'b0, d_stall = 1'b0, d_flush = 1'b0, d_pred_taken = 1'b0;
  logic [5:0]  opD = '0;
  logic [4:0]  rtD = '0;
  logic [31:0] branch_cnt, mispredict_cnt;

  branch_cmp_bht u_dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .d_valid(d_valid), .d_stall(d_stall), .d_flush(d_flush), .d_pc(d_pc),
    .opD(opD), .rtD(rtD), .a(a), .b(b), .d_pred_taken(d_pred_taken),
    .d_is_branch(d_is_branch), .d_taken(d_taken), .r_valid(r_valid),
    .r_taken(r_taken), .r_mispredict(r_mispredict), .r_pc(r_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  // narrow instance
  logic [15:0] s_f_pc = '0, s_d_pc = '0, s_a = '0, s_b = '0, s_r_pc;
  logic        s_f_pred, s_is_branch, s_taken, s_r_valid, s_r_taken, s_r_misp;
  logic        s_valid = 1'b0, s_pred = 1'b0;
  logic [5:0]  s_op = '0;
  logic [4:0]  s_rt = '0;
  logic [3:0]  s_branch_cnt, s_misp_cnt;

  branch_cmp_bht #(.DATA_W(16), .PC_W(16), .BHT_DEPTH(4), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .f_pc(s_f_pc), .f_pred_taken(s_f_pred),
    .d_valid(s_valid), .d_stall(1'b0), .d_flush(1'b0), .d_pc(s_d_pc),
    .opD(s_op), .rtD(s_rt), .a(s_a), .b(s_b), .d_pred_taken(s_pred),
    .d_is_branch(s_is_branch), .d_taken(s_taken), .r_valid(s_r_valid),
    .r_taken(s_r_taken), .r_mispredict(s_r_misp), .r_pc(s_r_pc),
    .branch_cnt(s_branch_cnt), .mispredict_cnt(s_misp_cnt)
  );

  typedef struct packed { logic taken; logic misp; logic [31:0] pc; } exp_t;
  exp_t sb_q[$];

  typedef struct packed {
    logic [5:0] op; logic [4:0] rt; logic [31:0] av; logic [31:0] bv; logic br; logic tk;
  } dcase_t;
  dcase_t dtab [16];

  int checks = 0;
  int passed = 0;

  // scoreboard: every resolved branch must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && r_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: r_valid=1 pc=%h, want no resolve", r_pc);
      end else begin
        e = sb_q.pop_front();
        if ({r_taken, r_mispredict, r_pc} !== {e.taken, e.misp, e.pc})
          $display("FAIL sb_resolve: got taken=%b misp=%b pc=%h, want taken=%b misp=%b pc=%h",
                   r_taken, r_mispredict, r_pc, e.taken, e.misp, e.pc);
        else begin
          passed++;
          $display("resolve pc=%h taken=%b misp=%b", r_pc, r_taken, r_mispredict);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rt,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic pred, input logic [31:0] pc);
    d_valid = v; opD = op; rtD = rt; a = av; b = bv; d_pred_taken = pred; d_pc = pc;
  endtask

  task automatic push_exp(input logic t, input logic m, input logic [31:0] pc);
    exp_t e;
    e.taken = t; e.misp = m; e.pc = pc;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({r_valid, r_taken, r_mispredict} !== 3'b000 || r_pc !== 32'h0)
      $display("FAIL reset_r: got v=%b t=%b m=%b pc=%h, want 0", r_valid, r_taken, r_mispredict, r_pc);
    else passed++;
    checks++;
    if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0)
      $display("FAIL reset_cnt: got %0d/%0d, want 0/0", branch_cnt, mispredict_cnt);
    else passed++;
    f_pc = 32'h0040_0010;
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) $display("FAIL reset_pred: got %b, want 0", f_pred_taken);
    else passed++;
    $display("reset done");
  endtask

  task automatic test_decode();
    dtab = '{
      '{OP_BEQ,    5'h00, 32'h5,         32'h5, 1'b1, 1'b1},
      '{OP_BEQ,    5'h00, 32'h5,         32'h6, 1'b1, 1'b0},
      '{OP_BNE,    5'h00, 32'h5,         32'h6, 1'b1, 1'b1},
      '{OP_BNE,    5'h00, 32'h7,         32'h7, 1'b1, 1'b0},
      '{OP_BGTZ,   5'h00, 32'h1,         32'h0, 1'b1, 1'b1},
      '{OP_BGTZ,   5'h00, 32'h0,         32'h0, 1'b1, 1'b0},
      '{OP_BGTZ,   5'h00, 32'h8000_0000, 32'h0, 1'b1, 1'b0},
      '{OP_BLEZ,   5'h00, 32'h8000_0000, 32'h0, 1'b1, 1'b1},
      '{OP_BLEZ,   5'h00, 32'h0,         32'h0, 1'b1, 1'b1},
      '{OP_BLEZ,   5'h00, 32'h1,         32'h0, 1'b1, 1'b0},
      '{OP_REGIMM, 5'h01, 32'h0,         32'h0, 1'b1, 1'b1},
      '{OP_REGIMM, 5'h00, 32'h8000_0000, 32'h0, 1'b1, 1'b1},
      '{OP_REGIMM, 5'h10, 32'h5,         32'h0, 1'b1, 1'b0},
      '{OP_REGIMM, 5'h11, 32'h5,         32'h0, 1'b1, 1'b1},
      '{OP_REGIMM, 5'h03, 32'h8000_0000, 32'h0, 1'b0, 1'b0},
      '{6'h23,     5'h00, 32'h9,         32'h9, 1'b0, 1'b0}
    };
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, dtab[i].op, dtab[i].rt, dtab[i].av, dtab[i].bv, 1'b0, 32'h0);
      #1;
      checks++;
      if ({d_is_branch, d_taken} !== {dtab[i].br, dtab[i].tk})
        $display("FAIL decode_%0d: got br=%b tk=%b, want br=%b tk=%b",
                 i, d_is_branch, d_taken, dtab[i].br, dtab[i].tk);
      else passed++;
      $display("decode op=%h rt=%h a=%h b=%h br=%b tk=%b", dtab[i].op, dtab[i].rt,
               dtab[i].av, dtab[i].bv, d_is_branch, d_taken);
    end
    tick();
    checks++;
    if (r_valid !== 1'b0) $display("FAIL decode_no_fire: got r_valid=%b, want 0", r_valid);
    else passed++;
  endtask

  task automatic test_resolve();
    f_pc = 32'h0040_0104;
    drive(1'b1, OP_BEQ, 5'h0, 32'h1234, 32'h1234, 1'b0, 32'h0040_0104);
    push_exp(1'b1, 1'b1, 32'h0040_0104);
    tick();
    d_valid = 1'b0;
    checks++;
    if (r_valid !== 1'b1 || branch_cnt !== 32'd0)
      $display("FAIL resolve_lat: got r_valid=%b cnt=%0d, want 1/0", r_valid, branch_cnt);
    else passed++;
    tick();
    checks++;
    if (branch_cnt !== 32'd1 || mispredict_cnt !== 32'd1 || r_valid !== 1'b0)
      $display("FAIL resolve_cnt: got %0d/%0d v=%b, want 1/1 v=0", branch_cnt, mispredict_cnt, r_valid);
    else passed++;
    checks++;
    if (f_pred_taken !== 1'b1) $display("FAIL resolve_pred: got %b, want 1", f_pred_taken);
    else passed++;
  endtask

  task automatic test_bht_train();
    logic [3:0] want_pred;
    f_pc = 32'h0040_0020;
    drive(1'b1, OP_BEQ, 5'h0, 32'h1, 32'h1, 1'b0, 32'h0040_0020);
    push_exp(1'b1, 1'b1, 32'h0040_0020);
    #1;
    checks++;
    if (f_pred_taken !== 1'b0) $display("FAIL train_pred0: got %b, want 0", f_pred_taken);
    else passed++;
    want_pred = 4'b1110; // after edges 1..4: old value still visible on edge 1
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 2) begin
        d_pred_taken = 1'b1;
        push_exp(1'b1, 1'b0, 32'h0040_0020);
      end else d_valid = 1'b0;
      #1;
      checks++;
      if (f_pred_taken !== want_pred[i])
        $display("FAIL train_up_%0d: got %b, want %b", i, f_pred_taken, want_pred[i]);
      else passed++;
    end
    checks++;
    if (branch_cnt !== 32'd4 || mispredict_cnt !== 32'd2)
      $display("FAIL train_cnt: got %0d/%0d, want 4/2", branch_cnt, mispredict_cnt);
    else passed++;
    drive(1'b1, OP_BNE, 5'h0, 32'h1, 32'h1, 1'b1, 32'h0040_0020);
    push_exp(1'b0, 1'b1, 32'h0040_0020);
    tick();
    push_exp(1'b0, 1'b1, 32'h0040_0020);
    tick();
    d_valid = 1'b0;
    #1;
    checks++;
    if (f_pred_taken !== 1'b1) $display("FAIL train_dn_0: got %b, want 1", f_pred_taken);
    else passed++;
    tick();
    checks++;
    if (f_pred_taken !== 1'b0) $display("FAIL train_dn_1: got %b, want 0", f_pred_taken);
    else passed++;
    checks++;
    if (branch_cnt !== 32'd6 || mispredict_cnt !== 32'd4)
      $display("FAIL train_cnt2: got %0d/%0d, want 6/4", branch_cnt, mispredict_cnt);
    else passed++;
  endtask

  task automatic test_regimm();
    drive(1'b1, OP_REGIMM, 5'h11, 32'h5, 32'h0, 1'b1, 32'h0040_0040);
    #1;
    checks++;
    if ({d_is_branch, d_taken} !== 2'b11)
      $display("FAIL regimm_bgezal: got br=%b tk=%b, want 1 1", d_is_branch, d_taken);
    else passed++;
    push_exp(1'b1, 1'b0, 32'h0040_0040);
    tick();
    drive(1'b1, OP_REGIMM, 5'h03, 32'h5, 32'h0, 1'b0, 32'h0040_0044);
    #1;
    checks++;
    if ({d_is_branch, d_taken} !== 2'b00)
      $display("FAIL regimm_bad_rt: got br=%b tk=%b, want 0 0", d_is_branch, d_taken);
    else passed++;
    tick();
    d_valid = 1'b0;
    checks++;
    if (r_valid !== 1'b0) $display("FAIL regimm_no_cap: got r_valid=%b, want 0", r_valid);
    else passed++;
    tick();
    checks++;
    if (branch_cnt !== 32'd7) $display("FAIL regimm_cnt: got %0d, want 7", branch_cnt);
    else passed++;
  endtask

  task automatic test_stall_flush();
    logic [1:0] combos [3];
    combos = '{2'b10, 2'b11, 2'b01};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_BEQ, 5'h0, 32'h3, 32'h3, 1'b0, 32'h0040_0060);
      {d_stall, d_flush} = combos[i];
      tick();
      checks++;
      if (r_valid !== 1'b0)
        $display("FAIL hold_%0d: stall=%b flush=%b got r_valid=%b, want 0",
                 i, d_stall, d_flush, r_valid);
      else passed++;
      $display("hold stall=%b flush=%b r_valid=%b", d_stall, d_flush, r_valid);
    end
    {d_valid, d_stall, d_flush} = 3'b000;
    tick();
    checks++;
    if (branch_cnt !== 32'd7) $display("FAIL hold_cnt: got %0d, want 7", branch_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic t;
    for (int i = 0; i < 6; i++) begin
      t = (i != 2);
      drive(1'b1, OP_BNE, 5'h0, 32'(i), 32'h2, 1'(i), 32'h0040_0080 + 32'(4 * i));
      push_exp(t, t ^ 1'(i), 32'h0040_0080 + 32'(4 * i));
      tick();
    end
    d_valid = 1'b0;
    tick();
    checks++;
    if (branch_cnt !== 32'd13 || mispredict_cnt !== 32'd6)
      $display("FAIL b2b_cnt: got %0d/%0d, want 13/6", branch_cnt, mispredict_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    f_pc = 32'h0040_0104;
    drive(1'b1, OP_BEQ, 5'h0, 32'h9, 32'h9, 1'b0, 32'h0040_0104);
    #1;
    checks++;
    if (f_pred_taken !== 1'b1) $display("FAIL mid_pre_pred: got %b, want 1", f_pred_taken);
    else passed++;
    tick();
    d_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    sb_q.delete();
    checks++;
    if ({r_valid, r_taken, r_mispredict} !== 3'b000 || r_pc !== 32'h0)
      $display("FAIL mid_r: got v=%b t=%b m=%b pc=%h, want 0", r_valid, r_taken, r_mispredict, r_pc);
    else passed++;
    checks++;
    if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0)
      $display("FAIL mid_cnt: got %0d/%0d, want 0/0", branch_cnt, mispredict_cnt);
    else passed++;
    for (int i = 0; i < 64; i++) begin
      f_pc = 32'h0040_0000 + 32'(4 * i);
      #0.1;
      checks++;
      if (f_pred_taken !== 1'b0) $display("FAIL mid_bht_%0d: got %b, want 0", i, f_pred_taken);
      else passed++;
    end
    $display("mid-stream reset applied");
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, OP_BEQ, 5'h0, 32'h9, 32'h9, 1'b1, 32'h0040_0104);
    push_exp(1'b1, 1'b0, 32'h0040_0104);
    tick();
    d_valid = 1'b0;
    tick();
    checks++;
    if (branch_cnt !== 32'd1 || mispredict_cnt !== 32'd0)
      $display("FAIL mid_after: got %0d/%0d, want 1/0", branch_cnt, mispredict_cnt);
    else passed++;
  endtask

  task automatic test_small();
    s_op = OP_REGIMM; s_rt = 5'h00; s_a = 16'h8000; s_d_pc = 16'h0010; s_f_pc = 16'h0010;
    #1;
    checks++;
    if ({s_is_branch, s_taken} !== 2'b11)
      $display("FAIL small_bltz: got br=%b tk=%b, want 1 1", s_is_branch, s_taken);
    else passed++;
    s_op = OP_BGTZ;
    #1;
    checks++;
    if (s_taken !== 1'b0) $display("FAIL small_bgtz_neg: got %b, want 0", s_taken);
    else passed++;
    s_a = 16'h7fff;
    #1;
    checks++;
    if (s_taken !== 1'b1) $display("FAIL small_bgtz_pos: got %b, want 1", s_taken);
    else passed++;
    s_op = OP_REGIMM; s_a = 16'h8000; s_valid = 1'b1; s_pred = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    s_valid = 1'b0;
    tick();
    checks++;
    if (s_branch_cnt !== 4'd15 || s_misp_cnt !== 4'd15)
      $display("FAIL small_sat: got %0d/%0d, want 15/15", s_branch_cnt, s_misp_cnt);
    else passed++;
    repeat (3) tick();
    checks++;
    if (s_branch_cnt !== 4'd15 || s_f_pred !== 1'b1)
      $display("FAIL small_hold: got cnt=%0d pred=%b, want 15/1", s_branch_cnt, s_f_pred);
    else passed++;
    $display("small instance: cnt=%0d misp=%0d", s_branch_cnt, s_misp_cnt);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_resolve();
    test_bht_train();
    test_regimm();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid();
    test_small();
    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
